sdpb_ram_param: RTL and testbench
=================================

Name: sdpb_ram_param

Overview:
- Parametrised single-clock simple dual-port block RAM for the backlight datapath: one write port (A) and one read port (B).
- Successor to the fixed 512x16 SDPB instance. Adds:
  - configurable width and depth
  - per-byte write enables
  - selectable read latency (1 or 2)
  - defined read-during-write behaviour
  - a hardware clear sequencer that fills the array with a constant after reset or on request
- Sits between the dimming-zone calculators and the LED driver line buffers.

Parameters:
DATA_W, 16, data width in bits; must be a multiple of 8
ADDR_W, 9, address width; depth = 2**ADDR_W
OUT_REG, 1, 0 = read latency 1 with no output register; 1 = read latency 2 with the output register gated by oce
RDW_NEW, 1, read and write to the same address in the same cycle: 1 = read returns newly written data, 0 = read returns old data
CLR_ON_RESET, 1, 1 = clear sequence starts automatically when reset deasserts
CLR_VALUE, 0, DATA_W-bit value written by the clear sequence

Ports:
clk  in  1  single clock for both ports
reset  in  1  synchronous, active-high reset
cea  in  1  write enable, port A
ada  in  ADDR_W  write address
din  in  DATA_W  write data
bea  in  DATA_W/8  byte enables; bit i covers din[8i+7:8i]
ceb  in  1  read enable, port B
adb  in  ADDR_W  read address
oce  in  1  output register enable; ignored when OUT_REG=0
dout  out  DATA_W  read data
dout_vld  out  1  dout holds data from an accepted read
clr_req  in  1  one-cycle pulse that starts a clear sequence
busy  out  1  clear sequence in progress

Behaviour:
- Reset values:
  - dout = 0, dout_vld = 0, all pipeline valid flags = 0
  - FSM = CLEAR with the address counter at 0 if CLR_ON_RESET=1, otherwise IDLE
  - busy follows the FSM state
  - Array contents are not reset.
- FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR: clr_req=1 (counter loads 0).
  - CLEAR: each cycle writes CLR_VALUE to the counter address (all bytes), then increments the counter.
  - CLEAR -> IDLE: after writing address 2**ADDR_W-1. The clear takes exactly 2**ADDR_W cycles.
  - busy = 1 exactly while in CLEAR.
- While busy=1:
  - cea and ceb are ignored.
  - No new reads are accepted; reads already in the pipeline complete normally.
  - clr_req is ignored; the sequence does not restart.
- Reset asserted at any time, including mid-clear, returns to the reset state. A clear is restarted from address 0 when CLR_ON_RESET=1.
- Reset and clr_req in the same cycle: reset wins.
- Write: on a clk edge with cea=1 and busy=0, each byte with bea[i]=1 updates mem[ada]; bytes with bea[i]=0 are unchanged. cea=1 with bea=0 changes nothing.
- Read path, OUT_REG=0:
  - On a clk edge with ceb=1 and busy=0, dout loads mem[adb] and dout_vld=1 for the next cycle.
  - With ceb=0, dout holds its value and dout_vld=0.
- Read path, OUT_REG=1:
  - Stage 1 register and its valid flag load on ceb=1, busy=0.
  - The output register loads from stage 1 on edges with oce=1. dout_vld = stage-1 valid at that load.
  - With oce=0, dout and dout_vld hold.
  - A new read while stage 1 is valid and oce=0 overwrites stage 1; there is no backpressure.
- Read-during-write, ada==adb with cea=ceb=1:
  - RDW_NEW=1: read data is the byte-wise merge, enabled bytes from din and the rest from old contents.
  - RDW_NEW=0: read data is the old contents.
  - Different addresses never interact.
- Address wrap: the clear counter is ADDR_W+1 bits; there is no wrap into a second pass.
- Reads of never-written, never-cleared locations return unknown data. The bench must not check them.

Test Plan:
1. DATA_W=16, ADDR_W=4, CLR_ON_RESET=1, CLR_VALUE=16'hA5A5; release reset -> busy=1 for exactly 16 cycles; reads of addresses 0..15 then return 16'hA5A5.
2. Write 16'h1234 to address 3 with bea=2'b11, then 16'hFF00 with bea=2'b10 -> read of address 3 returns 16'hFF34. Latency checks: OUT_REG=0 gives dout_vld one cycle after ceb; OUT_REG=1 with oce=1 gives dout_vld two cycles after ceb.
3. Same-cycle write of 16'hBEEF and read of address 5, with old contents 16'h0000 -> RDW_NEW=1 returns 16'hBEEF; RDW_NEW=0 returns 16'h0000, and a later read returns 16'hBEEF.
4. OUT_REG=1: read address 1 (holds 16'h0011), hold oce=0 for 3 cycles, then read address 2 (holds 16'h0022), then oce=1 -> dout=16'h0022 with dout_vld pulsed once; the earlier 16'h0011 is never presented.
5. clr_req mid-operation, then reset asserted at clear cycle 7 -> clear restarts at address 0 with busy=1 for a full 16 cycles. cea/ceb applied during busy cause no write and no dout_vld.
6. CLR_ON_RESET=0 -> busy=0 after reset. A single clr_req pulse followed by a second pulse during busy -> exactly one 16-cycle clear.

Source files
------------

// File: rtl/sdpb_ram_param_if.sv
// Port-side bundle of the simple dual-port RAM: write port A, read port B, clear control.
// master drives requests (zone calculators / test driver); slave is the RAM itself.
interface sdpb_ram_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic                  cea;
    logic [ADDR_W-1:0]     ada;
    logic [DATA_W-1:0]     din;
    logic [DATA_W/8-1:0]   bea;
    logic                  ceb;
    logic [ADDR_W-1:0]     adb;
    logic                  oce;
    logic [DATA_W-1:0]     dout;
    logic                  dout_vld;
    logic                  clr_req;
    logic                  busy;

    modport master (
        output cea, ada, din, bea, ceb, adb, oce, clr_req,
        input  dout, dout_vld, busy
    );

    modport slave (
        input  cea, ada, din, bea, ceb, adb, oce, clr_req,
        output dout, dout_vld, busy
    );
endinterface

// File: rtl/sdpb_ram_param.sv
// Parametrised simple dual-port RAM with byte-enable writes and a clear sequencer.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1, output stage advances on oce).
// No backpressure: a new read overwrites an unconsumed stage-1 word; busy blocks all port traffic.
module sdpb_ram_param #(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 9,
    parameter int                OUT_REG      = 1,
    parameter int                RDW_NEW      = 1,
    parameter int                CLR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLR_VALUE    = '0
) (
    input  logic              clk,
    input  logic              reset,
    sdpb_ram_param_if.slave   bus
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t              state;
    logic                busy_q;
    logic [ADDR_W:0]     clr_cnt;
    logic [ADDR_W:0]     clr_cnt_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_en;
    logic                wr_user;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NB-1:0]       wr_be;

    logic                rd_en;
    logic [DATA_W-1:0]   rd_data;

    logic [DATA_W-1:0]   dout_q;
    logic                dout_vld_q;

    assign clr_cnt_nxt = clr_cnt + 1'b1;

    // Clear sequencer: the carry into the extra counter bit marks the last address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            busy_q  <= (CLR_ON_RESET != 0);
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state   <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt_nxt;
                    if (clr_cnt_nxt[ADDR_W]) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_user = !reset && !busy_q && bus.cea;
    assign rd_en   = !reset && !busy_q && bus.ceb;

    // Single write port shared between the clear sequencer and port A.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.ada;
        wr_data = bus.din;
        wr_be   = bus.bea;
        if (!reset && busy_q) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt[ADDR_W-1:0];
            wr_data = CLR_VALUE;
            wr_be   = '1;
        end else if (wr_user) begin
            wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Same-address collision: merge the enabled write bytes over the stored word.
    always_comb begin
        rd_data = mem[bus.adb];
        if ((RDW_NEW != 0) && wr_user && (bus.ada == bus.adb)) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.bea[i]) begin
                    rd_data[8*i +: 8] = bus.din[8*i +: 8];
                end
            end
        end
    end

    if (OUT_REG == 0) begin : g_lat1
        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q     <= '0;
                dout_vld_q <= 1'b0;
            end else begin
                dout_vld_q <= rd_en;
                if (rd_en) begin
                    dout_q <= rd_data;
                end
            end
        end
    end else begin : g_lat2
        logic [DATA_W-1:0] s1_dat;
        logic              s1_vld;

        always_ff @(posedge clk) begin
            if (rd_en) begin
                s1_dat <= rd_data;
            end
        end

        // Stage-1 valid is consumed by an oce load, so each read is presented at most once.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_vld     <= 1'b0;
                dout_q     <= '0;
                dout_vld_q <= 1'b0;
            end else begin
                if (rd_en) begin
                    s1_vld <= 1'b1;
                end else if (bus.oce) begin
                    s1_vld <= 1'b0;
                end
                if (bus.oce) begin
                    dout_q     <= s1_dat;
                    dout_vld_q <= s1_vld;
                end
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
endmodule

// File: tb/tb_sdpb_ram_param.sv
// Bench for sdpb_ram_param: two instances (latency 2 / new-data RDW / clear on reset, and
// latency 1 / old-data RDW / no clear on reset) driven with shared stimulus.
module tb_sdpb_ram_param;
    logic        clk;
    logic        reset;
    logic        cea, ceb, oce, clr_req;
    logic [3:0]  ada, adb;
    logic [15:0] din;
    logic [1:0]  bea;

    int checks;
    int errors;
    bit mdl_on;

    sdpb_ram_param_if #(.DATA_W(16), .ADDR_W(4)) if_a ();
    sdpb_ram_param_if #(.DATA_W(16), .ADDR_W(4)) if_b ();

    assign if_a.cea = cea;  assign if_a.ada = ada;  assign if_a.din = din;  assign if_a.bea = bea;
    assign if_a.ceb = ceb;  assign if_a.adb = adb;  assign if_a.oce = oce;  assign if_a.clr_req = clr_req;
    assign if_b.cea = cea;  assign if_b.ada = ada;  assign if_b.din = din;  assign if_b.bea = bea;
    assign if_b.ceb = ceb;  assign if_b.adb = adb;  assign if_b.oce = oce;  assign if_b.clr_req = clr_req;

    sdpb_ram_param #(
        .DATA_W(16), .ADDR_W(4), .OUT_REG(1), .RDW_NEW(1), .CLR_ON_RESET(1), .CLR_VALUE(16'hA5A5)
    ) u_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );

    sdpb_ram_param #(
        .DATA_W(16), .ADDR_W(4), .OUT_REG(0), .RDW_NEW(0), .CLR_ON_RESET(0), .CLR_VALUE(16'h0000)
    ) u_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory image with per-bit "known" masks, and the read pipeline as
    // a stage-1 slot plus output word, advanced once per clock edge.
    bit          p_oreg [2];
    bit          p_rnew [2];
    bit          p_clrr [2];
    logic [15:0] p_clrv [2];

    logic [15:0] m_mem  [2][16];
    logic [15:0] m_kn   [2][16];
    bit          m_busy [2];
    int          m_cnt  [2];
    logic [15:0] m_s1   [2];
    logic [15:0] m_s1k  [2];
    bit          m_s1v  [2];
    logic [15:0] m_do   [2];
    logic [15:0] m_dok  [2];
    bit          m_dv   [2];

    typedef struct {
        logic        cea;
        logic [3:0]  ada;
        logic [15:0] din;
        logic [1:0]  bea;
        logic        ceb;
        logic [3:0]  adb;
        logic        oce;
        logic        a_vld;
        logic [15:0] a_dout;
        logic        b_vld;
        logic [15:0] b_dout;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        logic [15:0] rv, rk;
        bit acc_w, acc_r;
        if (reset) begin
            m_busy[k] = p_clrr[k];
            m_cnt[k]  = 0;
            m_do[k]   = 16'h0000;
            m_dok[k]  = 16'hFFFF;
            m_dv[k]   = 1'b0;
            m_s1v[k]  = 1'b0;
            return;
        end
        acc_w = !m_busy[k] && cea;
        acc_r = !m_busy[k] && ceb;
        rv = m_mem[k][adb];
        rk = m_kn[k][adb];
        if (acc_r && acc_w && (ada == adb) && p_rnew[k]) begin
            for (int b = 0; b < 2; b++) begin
                if (bea[b]) begin
                    rv[8*b +: 8] = din[8*b +: 8];
                    rk[8*b +: 8] = 8'hFF;
                end
            end
        end
        if (!p_oreg[k]) begin
            m_dv[k] = acc_r;
            if (acc_r) begin
                m_do[k]  = rv;
                m_dok[k] = rk;
            end
        end else begin
            if (oce) begin
                m_do[k]  = m_s1[k];
                m_dok[k] = m_s1k[k];
                m_dv[k]  = m_s1v[k];
            end
            if (acc_r) begin
                m_s1[k]  = rv;
                m_s1k[k] = rk;
                m_s1v[k] = 1'b1;
            end else if (oce) begin
                m_s1v[k] = 1'b0;
            end
        end
        if (m_busy[k]) begin
            m_mem[k][m_cnt[k]] = p_clrv[k];
            m_kn[k][m_cnt[k]]  = 16'hFFFF;
            m_cnt[k]++;
            if (m_cnt[k] == 16) m_busy[k] = 1'b0;
        end else begin
            if (acc_w) begin
                for (int b = 0; b < 2; b++) begin
                    if (bea[b]) begin
                        m_mem[k][ada][8*b +: 8] = din[8*b +: 8];
                        m_kn[k][ada][8*b +: 8]  = 8'hFF;
                    end
                end
            end
            if (clr_req) begin
                m_busy[k] = 1'b1;
                m_cnt[k]  = 0;
            end
        end
    endtask

    task automatic model_check();
        if (!mdl_on) return;
        check("mdl_busy_a", if_a.busy, m_busy[0]);
        check("mdl_vld_a", if_a.dout_vld, m_dv[0]);
        if (m_dok[0] != 16'h0000) check("mdl_dout_a", if_a.dout & m_dok[0], m_do[0] & m_dok[0]);
        check("mdl_busy_b", if_b.busy, m_busy[1]);
        check("mdl_vld_b", if_b.dout_vld, m_dv[1]);
        if (m_dok[1] != 16'h0000) check("mdl_dout_b", if_b.dout & m_dok[1], m_do[1] & m_dok[1]);
    endtask

    // One clock: model advances on the same edge as the DUTs, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (reset) mdl_on = 1'b1;
        model_step(0);
        model_step(1);
        #1;
        model_check();
    endtask

    task automatic sweep(input bit with_b);
        int nva, nvb;
        nva = 0;
        nvb = 0;
        cea = 1'b0; oce = 1'b1; clr_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            ceb = (c < 16);
            adb = 4'(c);
            tick();
            if (if_a.dout_vld) begin
                nva++;
                check("sweep_dout_a", if_a.dout, 16'hA5A5);
            end
            if (with_b && if_b.dout_vld) begin
                nvb++;
                check("sweep_dout_b", if_b.dout, 16'h0000);
            end
        end
        ceb = 1'b0;
        check("sweep_count_a", nva, 16);
        if (with_b) check("sweep_count_b", nvb, 16);
    endtask

    int na, nb;

    initial begin
        checks = 0;
        errors = 0;
        mdl_on = 1'b0;
        p_oreg = '{1'b1, 1'b0};
        p_rnew = '{1'b1, 1'b0};
        p_clrr = '{1'b1, 1'b0};
        p_clrv = '{16'hA5A5, 16'h0000};
        for (int k = 0; k < 2; k++) begin
            m_s1k[k] = 16'h0000;
            m_dok[k] = 16'h0000;
            for (int a = 0; a < 16; a++) m_kn[k][a] = 16'h0000;
        end

        //                cea ada    din       bea    ceb adb   oce  a_vld a_dout    b_vld b_dout
        tbl[0]  = '{1'b1, 4'd3, 16'h1234, 2'b11, 1'b0, 4'd0, 1'b1, 1'b0, 16'hA5A5, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 4'd3, 16'hFF00, 2'b10, 1'b0, 4'd0, 1'b1, 1'b0, 16'hA5A5, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 1'b0, 16'hA5A5, 1'b1, 16'hFF34};
        tbl[3]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1, 1'b1, 16'hFF34, 1'b0, 16'hFF34};
        tbl[4]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1, 1'b0, 16'hFF34, 1'b0, 16'hFF34};
        tbl[5]  = '{1'b1, 4'd5, 16'hBEEF, 2'b11, 1'b1, 4'd5, 1'b1, 1'b0, 16'hFF34, 1'b1, 16'h0000};
        tbl[6]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b1, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF};
        tbl[7]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF};
        tbl[8]  = '{1'b1, 4'd1, 16'h0011, 2'b11, 1'b0, 4'd0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF};
        tbl[9]  = '{1'b1, 4'd2, 16'h0022, 2'b11, 1'b0, 4'd0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF};
        tbl[10] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd1, 1'b0, 1'b0, 16'hBEEF, 1'b1, 16'h0011};
        tbl[11] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'h0011};
        tbl[12] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'h0011};
        tbl[13] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd2, 1'b0, 1'b0, 16'hBEEF, 1'b1, 16'h0022};
        tbl[14] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1, 1'b1, 16'h0022, 1'b0, 16'h0022};
        tbl[15] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0022, 1'b0, 16'h0022};
        tbl[16] = '{1'b1, 4'd2, 16'hFFFF, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0022, 1'b0, 16'h0022};
        tbl[17] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd2, 1'b1, 1'b0, 16'h0022, 1'b1, 16'h0022};
        tbl[18] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1, 1'b1, 16'h0022, 1'b0, 16'h0022};
        tbl[19] = '{1'b1, 4'd6, 16'h1111, 2'b11, 1'b1, 4'd7, 1'b1, 1'b0, 16'h0022, 1'b1, 16'h0000};
        tbl[20] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd6, 1'b1, 1'b1, 16'hA5A5, 1'b1, 16'h1111};
        tbl[21] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1, 1'b1, 16'h1111, 1'b0, 16'h1111};

        reset = 1'b1; cea = 1'b0; ceb = 1'b0; oce = 1'b1; clr_req = 1'b0;
        ada = 4'd0; adb = 4'd0; din = 16'h0000; bea = 2'b00;
        tick();
        tick();
        check("rst_busy_a", if_a.busy, 1'b1);
        check("rst_busy_b", if_b.busy, 1'b0);
        check("rst_dout_a", if_a.dout, 16'h0000);
        check("rst_dout_b", if_b.dout, 16'h0000);
        check("rst_vld_a", if_a.dout_vld, 1'b0);
        check("rst_vld_b", if_b.dout_vld, 1'b0);

        // Power-on clear of A alongside a requested clear of B; a second request
        // and port traffic arrive while both are busy and must be ignored.
        reset = 1'b0;
        clr_req = 1'b1;
        na = 1;
        nb = 0;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (if_a.busy) na++;
            if (if_b.busy) nb++;
            if (c >= 4 && c <= 16) begin
                check("busy_vld_a", if_a.dout_vld, 1'b0);
                check("busy_vld_b", if_b.dout_vld, 1'b0);
            end
            clr_req = (c == 4);
            cea = (c >= 3 && c <= 13);
            ceb = (c >= 3 && c <= 13);
            ada = 4'(c);
            adb = 4'(c);
            din = 16'hFFFF;
            bea = 2'b11;
        end
        cea = 1'b0; ceb = 1'b0; clr_req = 1'b0;
        check("clr_cycles_a", na, 16);
        check("clr_cycles_b", nb, 16);
        sweep(1'b1);

        for (int i = 0; i < 22; i++) begin
            cea = tbl[i].cea; ada = tbl[i].ada; din = tbl[i].din; bea = tbl[i].bea;
            ceb = tbl[i].ceb; adb = tbl[i].adb; oce = tbl[i].oce;
            tick();
            check($sformatf("tbl%0d_vld_a", i), if_a.dout_vld, tbl[i].a_vld);
            check($sformatf("tbl%0d_dout_a", i), if_a.dout, tbl[i].a_dout);
            check($sformatf("tbl%0d_vld_b", i), if_b.dout_vld, tbl[i].b_vld);
            check($sformatf("tbl%0d_dout_b", i), if_b.dout, tbl[i].b_dout);
        end
        cea = 1'b0; ceb = 1'b0; oce = 1'b1;

        // Clear interrupted by reset at its 7th cycle; reset also beats a same-cycle clr_req.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("midclr_busy_a", if_a.busy, 1'b1);
        check("midclr_busy_b", if_b.busy, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            cea = 1'b1; ceb = 1'b1; ada = 4'(c + 8); adb = 4'(c + 8); din = 16'h5A5A; bea = 2'b11;
            tick();
            check("midclr_vld_a", if_a.dout_vld, 1'b0);
            check("midclr_vld_b", if_b.dout_vld, 1'b0);
        end
        cea = 1'b0; ceb = 1'b0;
        reset = 1'b1;
        clr_req = 1'b1;
        tick();
        check("rst2_busy_a", if_a.busy, 1'b1);
        check("rst2_busy_b", if_b.busy, 1'b0);
        check("rst2_vld_a", if_a.dout_vld, 1'b0);
        reset = 1'b0;
        clr_req = 1'b0;
        cea = 1'b1; ceb = 1'b1; ada = 4'd9; adb = 4'd9; din = 16'h1357; bea = 2'b11;
        na = 1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (if_a.busy) na++;
            check("restart_vld_a", if_a.dout_vld, 1'b0);
            if (c == 14) begin
                cea = 1'b0;
                ceb = 1'b0;
            end
        end
        check("restart_cycles_a", na, 16);
        sweep(1'b0);

        for (int c = 0; c < 1500; c++) begin
            reset   = ($urandom_range(0, 299) == 0);
            clr_req = ($urandom_range(0, 99) == 0);
            cea     = 1'($urandom_range(0, 1));
            ceb     = 1'($urandom_range(0, 1));
            oce     = ($urandom_range(0, 3) != 0);
            ada     = 4'($urandom);
            adb     = ($urandom_range(0, 3) == 0) ? ada : 4'($urandom);
            din     = 16'($urandom);
            bea     = 2'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
